// File: rtl/id_fifo_pkg.sv
// Shared helpers for the ID FIFO: pointer widths and status bundle.
// Optional parity storage is enabled by ID_SYNC_FIFO_PARITY_EN.
package id_fifo_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int addr_w(input int depth);
    return clog2(depth);
  endfunction

  function automatic int ptr_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/id_fifo_ram.sv
// Storage array for the ID FIFO: one write port, one async read port.
// Contents are never reset; only valid slots are ever observed.
module id_fifo_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // write one entry per accepted push
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/id_sync_fifo.sv
// Single-clock FWFT FIFO for AXI IDs with level and sticky error flags.
// Define ID_SYNC_FIFO_PARITY_EN to store and check an even parity bit.
module id_sync_fifo
  import id_fifo_pkg::*;
#(
  parameter int DATA_W    = 9,
  parameter int DEPTH     = 128,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    write_en,
  input  logic                    read_en,
  input  logic                    clear_err,
  output logic [DATA_W-1:0]       data_out,
  output logic                    full,
  output logic                    almost_full,
  output logic                    empty,
  output logic                    almost_empty,
  output logic [clog2(DEPTH):0]   level,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    parity_err
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int PTR_W  = ptr_w(DEPTH);
`ifdef ID_SYNC_FIFO_PARITY_EN
  localparam int MEM_W  = DATA_W + 1;
`else
  localparam int MEM_W  = DATA_W;
`endif
  localparam logic [PTR_W-1:0] AF_L = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] AE_L = PTR_W'(AE_THRESH);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [PTR_W-1:0] lvl;
  logic             wr_acc, rd_acc;
  logic [MEM_W-1:0] wdata, rdata;
  fifo_status_t     stat;

  assign lvl = wptr_q - rptr_q;

  // status bundle straight from the registered pointers
  always_comb begin
    stat.empty        = (wptr_q == rptr_q);
    stat.full         = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                        (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
    stat.almost_full  = (lvl >= AF_L);
    stat.almost_empty = (lvl <= AE_L);
  end

  assign wr_acc = write_en && !stat.full;
  assign rd_acc = read_en && !stat.empty;

  // next pointers and sticky flags; a new set wins over clear
  always_comb begin
    wptr_d = wptr_q + PTR_W'(wr_acc);
    rptr_d = rptr_q + PTR_W'(rd_acc);
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (clear_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (write_en && stat.full) ovf_d = 1'b1;
    if (read_en && stat.empty) udf_d = 1'b1;
  end

  // pointer and flag registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

`ifdef ID_SYNC_FIFO_PARITY_EN
  logic par_q, par_d;

  assign wdata = {^data_in, data_in};

  // recheck stored parity on every accepted pop
  always_comb begin
    par_d = par_q;
    if (clear_err) par_d = 1'b0;
    if (rd_acc && (^rdata)) par_d = 1'b1;
  end

  // sticky parity error register
  always_ff @(posedge clk) begin
    if (!resetn) par_q <= 1'b0;
    else         par_q <= par_d;
  end

  assign parity_err = par_q;
`else
  assign wdata      = data_in;
  assign parity_err = 1'b0;
`endif

  id_fifo_ram #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc && resetn),
    .waddr (wptr_q[ADDR_W-1:0]),
    .wdata (wdata),
    .raddr (rptr_q[ADDR_W-1:0]),
    .rdata (rdata)
  );

  assign data_out     = stat.empty ? '0 : rdata[DATA_W-1:0];
  assign full         = stat.full;
  assign empty        = stat.empty;
  assign almost_full  = stat.almost_full;
  assign almost_empty = stat.almost_empty;
  assign level        = lvl;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
